jsoc_timer_sched: RTL and testbench

Round-robin scheduler that shares the single JSoc interval timer among `N_REQ` hardware requesters needing one-shot timeouts. It sits between the requesters and the timer's 16-bit register slave (addr 0 status, 1 control, 2 period_l, 3 period_h). For each granted request it programs the 32-bit period, starts the timer in one-shot mode with interrupt enabled, and waits for the timer irq or a cancel. It then stops and clears the timer and returns a completion pulse to the owner.

---
 rtl/jsoc_timer_sched.sv | 195 +++++++++++++++++++
 tb/tb_jsoc_timer_sched.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jsoc_timer_sched.sv
// Round-robin arbiter that shares one interval timer among N_REQ one-shot timeout requesters.
// Each grant programs the period, starts the timer, waits for irq or cancel, then clears it.
module jsoc_timer_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [32*N_REQ-1:0]    req_delay,
    input  logic [N_REQ-1:0]       cancel,
    output logic [N_REQ-1:0]       done,
    output logic                   done_cancelled,
    output logic                   busy,
    output logic [IDW-1:0]         grant_id,
    output logic [2:0]             tmr_address,
    output logic                   tmr_chipselect,
    output logic                   tmr_write_n,
    output logic [15:0]            tmr_writedata,
    input  logic                   tmr_irq
);

    localparam logic [15:0] CtlStartIto = 16'h0005;
    localparam logic [15:0] CtlStop     = 16'h0008;

    localparam logic [2:0] AddrStatus  = 3'd0;
    localparam logic [2:0] AddrControl = 3'd1;
    localparam logic [2:0] AddrPeriodL = 3'd2;
    localparam logic [2:0] AddrPeriodH = 3'd3;

    typedef enum logic [3:0] {
        StInitStop,
        StInitClr,
        StIdle,
        StWrPl,
        StWrPh,
        StWrCtl,
        StWait,
        StStop,
        StClr,
        StDone,
        StGap
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_q, last_d;
    logic [31:0]    delay_q, delay_d;
    logic           cancelled_q, cancelled_d;

    logic           pick_valid;
    logic [IDW-1:0] pick_id;
    logic [31:0]    delay_slice [N_REQ];

    for (genvar j = 0; j < N_REQ; j++) begin : g_slice
        assign delay_slice[j] = req_delay[32*j +: 32];
    end

    // Search from last_q+1 upward, wrapping, so the last grantee has the lowest priority.
    always_comb begin : rr_pick
        int unsigned    idx;
        logic [IDW-1:0] cand;
        pick_valid = 1'b0;
        pick_id    = '0;
        idx        = 0;
        cand       = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = 32'(last_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            cand = IDW'(idx);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StInitStop;
            grant_q     <= '0;
            last_q      <= IDW'(N_REQ - 1);
            delay_q     <= '0;
            cancelled_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            delay_q     <= delay_d;
            cancelled_q <= cancelled_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_d         = last_q;
        delay_d        = delay_q;
        cancelled_d    = cancelled_q;
        busy           = 1'b1;
        done           = '0;
        done_cancelled = 1'b0;
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = AddrStatus;
        tmr_writedata  = '0;

        unique case (state_q)
            StInitStop: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrControl;
                tmr_writedata  = CtlStop;
                state_d        = StInitClr;
            end
            StInitClr: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrStatus;
                state_d        = StIdle;
            end
            StIdle: begin
                busy = 1'b0;
                if (pick_valid) begin
                    grant_d     = pick_id;
                    last_d      = pick_id;
                    delay_d     = delay_slice[pick_id];
                    cancelled_d = 1'b0;
                    // A zero delay completes immediately without touching the timer.
                    state_d     = (delay_slice[pick_id] == 32'd0) ? StDone : StWrPl;
                end
            end
            StWrPl: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrPeriodL;
                tmr_writedata  = delay_q[15:0];
                state_d        = StWrPh;
            end
            StWrPh: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrPeriodH;
                tmr_writedata  = delay_q[31:16];
                state_d        = StWrCtl;
            end
            StWrCtl: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrControl;
                tmr_writedata  = CtlStartIto;
                state_d        = StWait;
            end
            StWait: begin
                // The one-shot has already stopped itself on irq, so only a clear is needed.
                if (tmr_irq) begin
                    cancelled_d = 1'b0;
                    state_d     = StClr;
                end else if (cancel[grant_q]) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrControl;
                tmr_writedata  = CtlStop;
                cancelled_d    = 1'b1;
                state_d        = StClr;
            end
            StClr: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = AddrStatus;
                state_d        = StDone;
            end
            StDone: begin
                done[grant_q]  = 1'b1;
                done_cancelled = cancelled_q;
                state_d        = StGap;
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StInitStop;
            end
        endcase
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_jsoc_timer_sched.sv
// Randomized bench for jsoc_timer_sched with a behavioural interval-timer model and a
// round-robin / write-sequence reference computed from the scheduling rules.
module tb_jsoc_timer_sched;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDW   = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_REQ-1:0]     req;
    logic [32*N_REQ-1:0]  req_delay;
    logic [N_REQ-1:0]     cancel;
    logic [N_REQ-1:0]     done;
    logic                 done_cancelled;
    logic                 busy;
    logic [IDW-1:0]       grant_id;
    logic [2:0]           tmr_address;
    logic                 tmr_chipselect;
    logic                 tmr_write_n;
    logic [15:0]          tmr_writedata;
    logic                 tmr_irq;

    always #5 clk = ~clk;

    jsoc_timer_sched #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .req_delay      (req_delay),
        .cancel         (cancel),
        .done           (done),
        .done_cancelled (done_cancelled),
        .busy           (busy),
        .grant_id       (grant_id),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_irq        (tmr_irq)
    );

    // Interval timer model: one-shot countdown, timeout flag cleared by a status write.
    logic [15:0] per_l = '0;
    logic [15:0] per_h = '0;
    logic [31:0] tcnt = '0;
    logic        trun = 1'b0;
    logic        tto = 1'b0;
    logic        tito = 1'b0;
    logic        force_irq = 1'b0;

    always @(posedge clk) begin
        if (tmr_chipselect && !tmr_write_n) begin
            case (tmr_address)
                3'd0: tto <= 1'b0;
                3'd1: begin
                    if (tmr_writedata[3]) begin
                        trun <= 1'b0;
                    end else if (tmr_writedata[2]) begin
                        trun <= 1'b1;
                        tcnt <= {per_h, per_l};
                        tito <= tmr_writedata[0];
                    end
                end
                3'd2: per_l <= tmr_writedata;
                3'd3: per_h <= tmr_writedata;
                default: ;
            endcase
        end else if (trun) begin
            if (tcnt <= 32'd1) begin
                tto  <= 1'b1;
                trun <= 1'b0;
            end else begin
                tcnt <= tcnt - 32'd1;
            end
        end
    end

    assign tmr_irq = (tto & tito) | force_irq;

    typedef struct {
        int addr;
        int data;
        int cyc;
        int seg;
    } wr_t;

    typedef struct {
        int id;
        int canc;
        int gid;
        int cyc;
        int irq_cyc;
    } done_t;

    wr_t   wr_q[$];
    done_t done_q[$];
    int    cyc = 0;
    int    irq_rise = -100;
    logic  irq_prev = 1'b0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    last_m = N_REQ - 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        wr_t   w;
        done_t d;
        @(negedge clk);
        cyc++;
        if (tmr_irq && !irq_prev) irq_rise = cyc;
        irq_prev = tmr_irq;
        if (tmr_chipselect && !tmr_write_n) begin
            w.addr = int'(tmr_address);
            w.data = int'(tmr_writedata);
            w.cyc  = cyc;
            w.seg  = done_q.size();
            wr_q.push_back(w);
        end
        if (done != '0) begin
            check("done_onehot", $countones(done), 1);
            d.id = -1;
            for (int i = 0; i < N_REQ; i++) if (done[i]) d.id = i;
            d.canc    = int'(done_cancelled);
            d.gid     = int'(grant_id);
            d.cyc     = cyc;
            d.irq_cyc = irq_rise;
            done_q.push_back(d);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        cancel = '0;
        force_irq = 1'b0;
        step();
        check("rst_done", done, 0);
        check("rst_busy", busy, 1);
        check("rst_grant_id", grant_id, 0);
        check("init_stop_bus", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 3'd1});
        check("init_stop_data", tmr_writedata, 16'h0008);
        reset = 1'b0;
        step();
        check("init_clr_bus", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 3'd0});
        check("init_clr_data", tmr_writedata, 16'h0000);
        check("init_clr_done", done, 0);
        step();
        check("idle_busy", busy, 0);
        check("idle_bus", {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
              {1'b0, 1'b1, 3'd0, 16'h0000});
        last_m = N_REQ - 1;
    endtask

    // All requests in mask rise together and each drops on its own done.
    task automatic run_round(input logic [N_REQ-1:0] mask, input logic [32*N_REQ-1:0] dly,
                             input logic [N_REQ-1:0] cxl, input bit sim);
        int               order[$];
        int               ea[$];
        int               ed[$];
        wr_t              segw[$];
        logic [N_REQ-1:0] pend;
        int               idx;
        int               budget;
        int               id;
        int               total;
        logic [31:0]      d;
        bit               ce;
        bit               sim_fired;

        pend = mask;
        while (pend != '0) begin
            for (int k = 1; k <= N_REQ; k++) begin
                idx = (last_m + k) % N_REQ;
                if (pend[idx]) begin
                    order.push_back(idx);
                    pend[idx] = 1'b0;
                    last_m = idx;
                    break;
                end
            end
        end

        wr_q.delete();
        done_q.delete();
        sim_fired = 1'b0;
        req_delay = dly;
        cancel = cxl;
        req = mask;
        budget = 0;
        while (req != '0 && budget < 5000) begin
            step();
            budget++;
            if (done != '0) begin
                req = req & ~done;
                cancel = cancel & ~done;
                force_irq = 1'b0;
            end
            if (sim && !sim_fired && tmr_chipselect && !tmr_write_n && tmr_address == 3'd1 &&
                tmr_writedata == 16'h0005) begin
                force_irq = 1'b1;
                cancel = req;
                sim_fired = 1'b1;
            end
        end
        check("round_drained", req, 0);
        req = '0;
        cancel = '0;
        force_irq = 1'b0;
        step();
        step();
        check("busy_after_round", busy, 0);
        if (!sim) check("timer_cleared", tto, 0);

        check("done_count", done_q.size(), order.size());
        total = 0;
        for (int j = 0; j < done_q.size() && j < order.size(); j++) begin
            id = order[j];
            d  = dly[32*id +: 32];
            ce = (d != 0) && cxl[id] && !sim;
            check("grant_order", done_q[j].id, id);
            check("grant_id", done_q[j].gid, id);
            check("done_cancelled", done_q[j].canc, ce);
            ea.delete();
            ed.delete();
            if (d != 0) begin
                ea.push_back(2); ed.push_back(int'(d[15:0]));
                ea.push_back(3); ed.push_back(int'(d[31:16]));
                ea.push_back(1); ed.push_back(5);
                if (ce) begin
                    ea.push_back(1); ed.push_back(8);
                end
                ea.push_back(0); ed.push_back(0);
            end
            total += ea.size();
            segw.delete();
            foreach (wr_q[m]) if (wr_q[m].seg == j) segw.push_back(wr_q[m]);
            check("write_count", segw.size(), ea.size());
            for (int m = 0; m < segw.size() && m < ea.size(); m++) begin
                check("write_addr", segw[m].addr, ea[m]);
                check("write_data", segw[m].data, ed[m]);
            end
            if (d != 0 && segw.size() >= 3) begin
                check("setup_back_to_back", segw[2].cyc - segw[0].cyc, 2);
                if (ce) check("cancel_latency", done_q[j].cyc - segw[2].cyc, 4);
                else    check("irq_latency", done_q[j].cyc - done_q[j].irq_cyc, 2);
            end
        end
        check("write_total", wr_q.size(), total);
    endtask

    logic [N_REQ-1:0]    m;
    logic [N_REQ-1:0]    cx;
    logic [32*N_REQ-1:0] dl;

    initial begin
        reset = 1'b1;
        req = '0;
        cancel = '0;
        req_delay = '0;
        do_reset();

        // Full house, then a re-raised requester 0 continues the rotation.
        dl = {4{32'd5}};
        run_round(4'b1111, dl, 4'b0000, 1'b0);
        run_round(4'b0001, dl, 4'b0000, 1'b0);
        // Large period, cancelled before expiry.
        dl = '0;
        dl[63:32] = 32'h0001_86A0;
        run_round(4'b0010, dl, 4'b0010, 1'b0);
        dl[95:64] = 32'd1000;
        run_round(4'b0100, dl, 4'b0100, 1'b0);
        // Non-grantee cancel must be ignored.
        dl = '0;
        dl[31:0] = 32'd20;
        run_round(4'b0001, dl, 4'b1000, 1'b0);

        for (int r = 0; r < 12; r++) begin
            m = N_REQ'($urandom_range(1, 15));
            for (int i = 0; i < N_REQ; i++) begin
                dl[32*i +: 32] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
            end
            cx = N_REQ'($urandom_range(0, 15)) & N_REQ'($urandom_range(0, 15));
            run_round(m, dl, cx, 1'b0);
        end

        // irq and grantee cancel in the same wait cycle; the timer is still running afterwards.
        dl = '0;
        dl[31:0] = 32'd1000;
        run_round(4'b0001, dl, 4'b0000, 1'b1);
        do_reset();

        // Zero delay completes one cycle after the grant with no timer traffic.
        done_q.delete();
        wr_q.delete();
        req_delay = '0;
        req = 4'b0001;
        step();
        check("zero_delay_done", done, 4'b0001);
        check("zero_delay_cancelled", done_cancelled, 0);
        req = '0;
        step();
        step();
        check("zero_delay_no_writes", wr_q.size(), 0);
        check("zero_delay_idle", busy, 0);

        // Reset while waiting abandons the request and re-runs init.
        done_q.delete();
        req_delay[31:0] = 32'd500;
        req = 4'b0001;
        step();
        check("grant_latency_bus", {tmr_chipselect, tmr_write_n, tmr_address}, {1'b1, 1'b0, 3'd2});
        check("grant_latency_data", tmr_writedata, 16'd500);
        repeat (10) step();
        check("wait_busy", busy, 1);
        do_reset();
        check("reset_no_done", done_q.size(), 0);
        check("reset_timer_stopped", trun, 0);

        // Pointer restarts at requester 0 after reset.
        dl = {4{32'd3}};
        run_round(4'b1010, dl, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
